tdc_record_streamer: RTL and testbench
======================================

# tdc_record_streamer

Buffers CAN timing records from the PLI TDC measurement block and streams them to the host as framed bytes. Each record is CAN ID, measured time and DLC, presented with a one-cycle write strobe. Records sit in a small FIFO and are serialized over a valid/ready byte interface, normally feeding the UART transmitter. The block paces capture against a slower byte sink and reports any records dropped because the FIFO was full.

## Interface
- DEPTH, 16, FIFO depth in records; power of two, minimum 2
- OVF_WIDTH, 8, overflow counter width
- CLK  in  1  system clock, 50 MHz
- RST  in  1  asynchronous, active-high reset
- ENABLE  in  1  capture enable; while low, strobes are ignored
- rec_valid  in  1  one-cycle write strobe from the measurement block
- rec_data  in  27  {CAN_ID[10:0], measure_time[11:0], DLC[3:0]}
- tx_data  out  8  byte to the sink
- tx_valid  out  1  tx_data is valid
- tx_ready  in  1  sink accepts the byte
- ovf_flag  out  1  sticky; set on the first dropped record
- ovf_count  out  OVF_WIDTH  dropped records, saturating
- busy  out  1  FIFO not empty, or a frame is in progress

## Operation
- **Push rule:** `rec_valid & ENABLE & (!full | pop_this_cycle)`.
  - Drop rule: `rec_valid & ENABLE & full & !pop`. A drop increments ovf_count, saturating at all-ones, and sets ovf_flag.
- **Payload word:** `{5'b0, rec_data}`, 32 bits, sent MSB byte first.
- **Frame:** SYNC (0xA5), P3, P2, P1, P0, CSUM.
  - CSUM is the sum of the payload bytes mod 256. SYNC is not included.
- **FSM states:** IDLE, SYNC, PAYLOAD, CSUM.
  - IDLE: if the FIFO is not empty, pop, load the shift register, clear the checksum and byte index, then go to SYNC.
  - SYNC: on handshake, go to PAYLOAD.
  - PAYLOAD: each handshake adds the byte to the checksum and shifts. After the last payload byte, go to CSUM.
  - CSUM: on handshake, go to IDLE.
- **Handshake:** a byte transfers when tx_valid & tx_ready are high at the CLK edge.
  - While tx_valid is high and tx_ready is low, tx_data is held stable.
  - tx_valid never drops without a transfer.
- **ENABLE low:** gates pushes only. A frame already in progress and any queued records still drain. Ignored strobes are not counted as drops.
- **Overflow clear:** ovf_flag and ovf_count clear only on RST.

## Timing
- **Reset values (asynchronous):** tx_valid=0, tx_data=0x00, ovf_flag=0, ovf_count=0, busy=0, FIFO empty, FSM in IDLE. Reset mid-frame abandons the frame; no partial bytes follow.
- **Latency:** a push into an empty FIFO at edge N gives the pop at edge N+1 and tx_valid=1 with 0xA5 after edge N+2.
- **Throughput:** with tx_ready held high, one byte per cycle. The next SYNC follows CSUM with one IDLE cycle between frames.
- **Full FIFO:** a push and pop in the same cycle when full accepts the push; the count stays at DEPTH.
- **Occupancy:** a count of DEPTH+1 records in flight, counting the one in the shift register, is legal.
- **Push when empty:** a push into an empty FIFO while IDLE is not popped in the same cycle; the pop happens next cycle.
- **Counter width:** the FIFO count register is $clog2(DEPTH)+1 bits wide, and the pointers wrap naturally.

## Configuration
- **TDC_REC_TIMESTAMP_EN defined:**
  - A 16-bit free-running counter, reset to 0, increments every CLK.
  - It is captured alongside each pushed record; the FIFO width becomes 43 bits.
  - The frame becomes SYNC=0xA6, P3..P0, T1, T0, CSUM. CSUM covers P3..T0.
  - The timestamp wraps 0xFFFF→0x0000 silently.
- **Undefined:** 27-bit FIFO entries and the 6-byte frame with SYNC=0xA5, as specified above.

## Structure
- **Package `tdc_rec_pkg`** holds:
  - SYNC_BYTE and SYNC_BYTE_TS constants.
  - The state enum (IDLE, SYNC, PAYLOAD, CSUM).
  - PAYLOAD_BYTES, which is 4 or 6 depending on the macro.
  - REC_W, which is 27 or 43 depending on the macro.
- **Sub-module `tdc_rec_fifo`:** synchronous FIFO with parameters WIDTH and DEPTH. Ports are push/pop, full/empty, and a same-cycle push-on-full-with-pop rule.
- The FSM, shift register, checksum and overflow logic live in the top level.

## Test plan
- **Single frame:** push rec_data={0x123,0x5AB,0x8} with tx_ready=1 → bytes A5 01 23 5A B8 36. tx_valid rises 2 cycles after the push. busy falls after the CSUM transfer.
- **Backpressure:** same record, with tx_ready toggling 1,0,0,1 repeatedly → identical byte sequence, and tx_data is stable during every ready-low cycle.
- **Overflow:** tx_ready=0, push 18 records with DEPTH=16 → 1 record is in the shift register, 16 are queued, 1 is dropped. ovf_count=1, ovf_flag=1. Releasing ready emits 17 frames in push order.
- **ENABLE:** ENABLE=0 while strobing 5 records → no frames, ovf_count=0. A frame already in progress when ENABLE falls completes intact.
- **Reset mid-frame:** assert RST after the 3rd byte → tx_valid=0 immediately. After release, the next pushed record starts cleanly with A5.
- **Timestamp variant (TDC_REC_TIMESTAMP_EN):** push at counter value 0x00FF → SYNC A6, then T1=00, T0=FF, and CSUM = (payload sum + 0xFF) mod 256. Also cover the timestamp wrap across 0xFFFF.

Source files
------------

// File: rtl/tdc_rec_pkg.sv
// tdc_rec_pkg: shared constants and types for the TDC record streamer.
//   SYNC_BYTE / SYNC_BYTE_TS : frame start markers (plain / timestamped frames)
//   state_t                  : framing FSM states
//   PAYLOAD_BYTES, REC_W     : payload length in bytes and FIFO entry width.
//                              Both depend on the TDC_REC_TIMESTAMP_EN macro.
package tdc_rec_pkg;

  localparam logic [7:0] SYNC_BYTE    = 8'hA5;
  localparam logic [7:0] SYNC_BYTE_TS = 8'hA6;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    PAYLOAD,
    CSUM
  } state_t;

`ifdef TDC_REC_TIMESTAMP_EN
  localparam int unsigned PAYLOAD_BYTES = 6;
  localparam int unsigned REC_W         = 43;
  localparam logic [7:0]  FRAME_SYNC    = SYNC_BYTE_TS;
`else
  localparam int unsigned PAYLOAD_BYTES = 4;
  localparam int unsigned REC_W         = 27;
  localparam logic [7:0]  FRAME_SYNC    = SYNC_BYTE;
`endif

endpackage

// File: rtl/tdc_rec_fifo.sv
// tdc_rec_fifo: synchronous show-ahead FIFO for TDC records.
//   CLK, RST        : clock, asynchronous active-high reset
//   push, wr_data   : write request and data
//   pop             : read request; rd_data shows the head entry while !empty
//   full, empty     : occupancy flags
// A push while full is accepted when a pop happens in the same cycle.
module tdc_rec_fifo #(
  parameter int unsigned WIDTH = 27,
  parameter int unsigned DEPTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers are exactly AW bits so they wrap at DEPTH without compare logic.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tdc_record_streamer.sv
// tdc_record_streamer: buffers CAN timing records and streams them as framed
// bytes over a valid/ready byte interface.
//   CLK, RST    : 50 MHz clock, asynchronous active-high reset
//   ENABLE      : capture enable (gates pushes only; queued data still drains)
//   rec_valid   : one-cycle record strobe
//   rec_data    : {CAN_ID[10:0], measure_time[11:0], DLC[3:0]}
//   tx_data/tx_valid/tx_ready : byte stream to the sink
//   ovf_flag    : sticky, set on the first dropped record
//   ovf_count   : saturating count of dropped records
//   busy        : FIFO not empty or a frame in progress
// Frame: SYNC, payload bytes MSB first, CSUM (sum of payload bytes mod 256).
// Optional macro TDC_REC_TIMESTAMP_EN appends a 16-bit free-running
// timestamp to each record (SYNC=0xA6, two extra payload bytes).
module tdc_record_streamer
  import tdc_rec_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned OVF_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 ENABLE,
  input  logic                 rec_valid,
  input  logic [26:0]          rec_data,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 ovf_flag,
  output logic [OVF_WIDTH-1:0] ovf_count,
  output logic                 busy
);

  localparam int unsigned SHR_W    = PAYLOAD_BYTES * 8;
  localparam logic [2:0]  LAST_IDX = 3'(PAYLOAD_BYTES - 1);

  state_t             state;
  logic [SHR_W-1:0]   shreg;
  logic [7:0]         csum_acc;
  logic [2:0]         byte_idx;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop;
  logic               push;
  logic               drop;
  logic               xfer;
  logic [REC_W-1:0]   wr_data;
  logic [REC_W-1:0]   rd_data;

  assign pop  = (state == IDLE) && !fifo_empty;
  assign push = rec_valid & ENABLE & (~fifo_full | pop);
  assign drop = rec_valid & ENABLE & fifo_full & ~pop;
  assign xfer = tx_valid & tx_ready;
  assign busy = !fifo_empty || (state != IDLE);

`ifdef TDC_REC_TIMESTAMP_EN
  logic [15:0] ts_count;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) ts_count <= '0;
    else     ts_count <= ts_count + 16'd1;
  end

  assign wr_data = {rec_data, ts_count};
`else
  assign wr_data = rec_data;
`endif

  tdc_rec_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .push    (push),
    .wr_data (wr_data),
    .pop     (pop),
    .rd_data (rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ovf_flag  <= 1'b0;
      ovf_count <= '0;
    end else if (drop) begin
      ovf_flag <= 1'b1;
      if (ovf_count != '1) ovf_count <= ovf_count + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      shreg    <= '0;
      csum_acc <= '0;
      byte_idx <= '0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            shreg    <= {5'b0, rd_data};
            csum_acc <= '0;
            byte_idx <= '0;
            state    <= SYNC;
          end
        end
        // First SYNC cycle only raises tx_valid; this is the second cycle of
        // push-to-valid latency. Afterwards tx_data advances on each transfer.
        SYNC: begin
          if (!tx_valid) begin
            tx_valid <= 1'b1;
            tx_data  <= FRAME_SYNC;
          end else if (tx_ready) begin
            tx_data <= shreg[SHR_W-1 -: 8];
            state   <= PAYLOAD;
          end
        end
        // tx_data always holds the top byte of shreg here; shifting after
        // each transfer exposes the next one.
        PAYLOAD: begin
          if (xfer) begin
            csum_acc <= csum_acc + tx_data;
            shreg    <= shreg << 8;
            byte_idx <= byte_idx + 3'd1;
            if (byte_idx == LAST_IDX) begin
              tx_data <= csum_acc + tx_data;
              state   <= CSUM;
            end else begin
              tx_data <= shreg[SHR_W-9 -: 8];
            end
          end
        end
        CSUM: begin
          if (xfer) begin
            tx_valid <= 1'b0;
            tx_data  <= '0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tdc_record_streamer.sv
module tb_tdc_record_streamer;

`ifdef TDC_REC_TIMESTAMP_EN
  localparam int         NP       = 6;
  localparam logic [7:0] SYNC_EXP = 8'hA6;
`else
  localparam int         NP       = 4;
  localparam logic [7:0] SYNC_EXP = 8'hA5;
`endif
  localparam int NB = NP + 2;

  typedef struct packed {
    logic [26:0] rec;
    logic [15:0] ts;
  } ent_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ENABLE = 1'b0;
  logic        rec_valid = 1'b0;
  logic [26:0] rec_data = '0;
  logic        tx_ready = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        ovf_flag;
  logic [7:0]  ovf_count;
  logic        busy;

  int   checks = 0;
  int   errors = 0;
  ent_t q[$];
  logic [7:0] got_b [8];
  logic [15:0] tb_ts;

  tdc_record_streamer #(
    .DEPTH     (16),
    .OVF_WIDTH (8)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .ENABLE    (ENABLE),
    .rec_valid (rec_valid),
    .rec_data  (rec_data),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .ovf_flag  (ovf_flag),
    .ovf_count (ovf_count),
    .busy      (busy)
  );

  always #10 CLK = ~CLK;

  // Reference free-running timestamp: value present before an edge is the
  // one captured with a record pushed on that edge.
  always @(posedge CLK or posedge RST) begin
    if (RST) tb_ts <= '0;
    else     tb_ts <= tb_ts + 16'd1;
  end

  initial begin
    repeat (150000) @(posedge CLK);
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [26:0] mk(input int i);
    logic [10:0] id;
    logic [11:0] t;
    logic [3:0]  d;
    id = 11'(i * 37 + 5);
    t  = 12'(i * 291 + 17);
    d  = 4'(i);
    return {id, t, d};
  endfunction

  function automatic logic [7:0] exp_byte(input ent_t e, input int i);
    logic [47:0] p;
    logic [7:0]  s;
`ifdef TDC_REC_TIMESTAMP_EN
    p = {5'b0, e.rec, e.ts};
`else
    p = {21'b0, e.rec};
`endif
    if (i == 0) return SYNC_EXP;
    if (i <= NP) return p[(NP-i)*8 +: 8];
    s = '0;
    for (int j = 1; j <= NP; j++) s = s + p[(NP-j)*8 +: 8];
    return s;
  endfunction

  // Called at a negedge; returns at the negedge after the strobe edge.
  task automatic push_rec(input logic [26:0] rec, input bit enq);
    ent_t e;
    rec_valid = 1'b1;
    rec_data  = rec;
    e.rec = rec;
    e.ts  = tb_ts;
    if (enq) q.push_back(e);
    @(negedge CLK);
    rec_valid = 1'b0;
  endtask

  // mode 0: ready held high; mode 1: ready pattern 1,0,0,1 repeating.
  task automatic recv_frame(input int mode, output int cycles);
    ent_t       e;
    int         k;
    int         budget;
    int         ph;
    logic       stall;
    logic [7:0] held;
    e = '0;
    if (q.size() > 0) e = q.pop_front();
    k = 0; budget = 400; ph = 0; stall = 1'b0; held = '0; cycles = 0;
    while (k < NB && budget > 0) begin
      tx_ready = (mode == 0) ? 1'b1 : ((ph % 4 == 0) || (ph % 4 == 3));
      ph++;
      #1;
      if (stall) begin
        check("hold_valid", 32'(tx_valid), 32'd1);
        check("hold_data", 32'(tx_data), 32'(held));
      end
      if (tx_valid && tx_ready) begin
        got_b[k] = tx_data;
        check($sformatf("byte%0d", k), 32'(tx_data), 32'(exp_byte(e, k)));
        k++;
        stall = 1'b0;
      end else begin
        stall = tx_valid;
        held  = tx_data;
      end
      @(negedge CLK);
      cycles++;
      budget--;
    end
    if (k < NB) check("frame_timeout", 32'(k), 32'(NB));
  endtask

  initial begin
    int cyc;
    int seen;
    int b;
    logic [7:0] hand [6];
    hand[0] = 8'hA5; hand[1] = 8'h01; hand[2] = 8'h23;
    hand[3] = 8'h5A; hand[4] = 8'hB8; hand[5] = 8'h36;

    repeat (3) @(negedge CLK);
    #1;
    check("rst_valid", 32'(tx_valid), 32'd0);
    check("rst_data", 32'(tx_data), 32'd0);
    check("rst_flag", 32'(ovf_flag), 32'd0);
    check("rst_count", 32'(ovf_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge CLK);
    RST = 1'b0; ENABLE = 1'b1; tx_ready = 1'b1;
    @(negedge CLK);

    // Single frame, latency and throughput
    push_rec({11'h123, 12'h5AB, 4'h8}, 1'b1);
    check("lat_n_valid", 32'(tx_valid), 32'd0);
    check("lat_n_busy", 32'(busy), 32'd1);
    @(negedge CLK);
    check("lat_n1_valid", 32'(tx_valid), 32'd0);
    @(negedge CLK);
    check("lat_n2_valid", 32'(tx_valid), 32'd1);
    check("lat_n2_data", 32'(tx_data), 32'(SYNC_EXP));
    recv_frame(0, cyc);
    check("throughput", 32'(cyc), 32'(NB));
    check("busy_end", 32'(busy), 32'd0);
`ifndef TDC_REC_TIMESTAMP_EN
    for (int i = 0; i < 6; i++) check($sformatf("hand%0d", i), 32'(got_b[i]), 32'(hand[i]));
`endif

    // Backpressure
    tx_ready = 1'b0;
    push_rec({11'h123, 12'h5AB, 4'h8}, 1'b1);
    recv_frame(1, cyc);
    check("bp_busy_end", 32'(busy), 32'd0);

    // ENABLE low ignores strobes
    ENABLE = 1'b0; tx_ready = 1'b1;
    for (int i = 0; i < 5; i++) push_rec(mk(100 + i), 1'b0);
    seen = 0;
    repeat (8) begin
      #1 seen += int'(tx_valid);
      @(negedge CLK);
    end
    check("en_no_frame", 32'(seen), 32'd0);
    check("en_ovf", 32'(ovf_count), 32'd0);
    check("en_busy", 32'(busy), 32'd0);

    // ENABLE falls with a frame in progress
    ENABLE = 1'b1;
    push_rec(mk(50), 1'b1);
    @(negedge CLK);
    @(negedge CLK);
    ENABLE = 1'b0;
    recv_frame(0, cyc);
    check("en_mid_busy", 32'(busy), 32'd0);
    ENABLE = 1'b1;

    // Overflow: 1 in shift register, 16 queued, 1 dropped
    tx_ready = 1'b0;
    for (int i = 0; i < 18; i++) push_rec(mk(i), i < 17);
    check("ovf_count", 32'(ovf_count), 32'd1);
    check("ovf_flag", 32'(ovf_flag), 32'd1);
    check("ovf_busy", 32'(busy), 32'd1);
    for (int f = 0; f < 17; f++) recv_frame(0, cyc);
    check("ovf_drain_busy", 32'(busy), 32'd0);
    check("ovf_sticky", 32'(ovf_count), 32'd1);

    // Reset mid-frame after 3 bytes
    tx_ready = 1'b1;
    push_rec(mk(200), 1'b0);
    @(negedge CLK);
    @(negedge CLK);
    repeat (3) @(negedge CLK);
    #5 RST = 1'b1;
    #1;
    check("rstmid_valid", 32'(tx_valid), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_ovf", 32'(ovf_count), 32'd0);
    check("rstmid_flag", 32'(ovf_flag), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    push_rec(mk(201), 1'b1);
    @(negedge CLK);
    check("rstmid_n1_valid", 32'(tx_valid), 32'd0);
    @(negedge CLK);
    check("rstmid_sync", 32'(tx_data), 32'(SYNC_EXP));
    recv_frame(0, cyc);

`ifdef TDC_REC_TIMESTAMP_EN
    // Push with timestamp 0x00FF
    b = 1000;
    while (tb_ts != 16'h00FF && b > 0) begin @(negedge CLK); b--; end
    push_rec({11'h123, 12'h5AB, 4'h8}, 1'b1);
    recv_frame(0, cyc);
    check("ts_sync", 32'(got_b[0]), 32'hA6);
    check("ts_t1", 32'(got_b[5]), 32'h00);
    check("ts_t0", 32'(got_b[6]), 32'hFF);
    check("ts_csum", 32'(got_b[7]), 32'h35);

    // Timestamp wrap: records at 0xFFFF and 0x0000
    b = 70000;
    while (tb_ts != 16'hFFFF && b > 0) begin @(negedge CLK); b--; end
    push_rec(mk(300), 1'b1);
    push_rec(mk(301), 1'b1);
    recv_frame(0, cyc);
    check("wrap_a_t1", 32'(got_b[5]), 32'hFF);
    check("wrap_a_t0", 32'(got_b[6]), 32'hFF);
    recv_frame(0, cyc);
    check("wrap_b_t1", 32'(got_b[5]), 32'h00);
    check("wrap_b_t0", 32'(got_b[6]), 32'h00);
`else
    b = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
